// File: rtl/alu_issue_ctrl.sv
// Issues one ALU operation per request handshake, waits a per-opcode latency, then
// returns the captured result/flags on a valid/ready response channel; owns HI/LO.
module alu_issue_ctrl #(
  parameter int WIDTH        = 32,
  parameter int OP_W         = 7,
  parameter int ALU_LATENCY  = 1,
  parameter int MULT_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [OP_W-1:0]  alu_aluOp,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [WIDTH-1:0] alu_lo,
  input  logic             alu_z,
  input  logic             alu_ov,
  input  logic             alu_cy,
  input  logic             alu_sign,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam int MAX_LAT = (ALU_LATENCY > MULT_LATENCY) ? ALU_LATENCY : MULT_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(1);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(2);

  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Gated by rst_n so the request side reads not-ready while reset is asserted.
  assign req_ready  = (state_q == S_IDLE) && rst_n;
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign alu_input1 = in1_q;
  assign alu_input2 = in2_q;
  assign alu_aluOp  = op_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign hi_reg     = hi_q;
  assign lo_reg     = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          in1_d   = req_a;
          in2_d   = req_b;
          op_d    = req_op;
          cnt_d   = is_mul(req_op) ? CNT_W'(MULT_LATENCY) : CNT_W'(ALU_LATENCY);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The edge that sees cnt==1 is the sample point for the ALU outputs.
        if (cnt_q == CNT_W'(1)) begin
          result_d = alu_result;
          flags_d  = {alu_sign, alu_cy, alu_ov, alu_z};
          if (is_mul(op_q)) begin
            hi_d = alu_hi;
            lo_d = alu_lo;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
